// File: rtl/rx_unit_if.sv
// rx_unit_if: RX-side SPM write port bundle.
// Driven by rx_unit; consumed by the SPM bus arbiter.
interface rx_unit_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] rx_spm_addr;
    logic [1:0]        rx_spm_en;
    logic              rx_spm_wr;
    logic [63:0]       rx_spm_wdata;

    modport master (
        output rx_spm_addr,
        output rx_spm_en,
        output rx_spm_wr,
        output rx_spm_wdata
    );

    modport slave (
        input rx_spm_addr,
        input rx_spm_en,
        input rx_spm_wr,
        input rx_spm_wdata
    );
endinterface

// File: rtl/rx_unit.sv
// rx_unit: NI receive path. Decodes flits from the router,
// writes payload words to the SPM, counts packets, flags errors.
module rx_unit #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [34:0]       i_pkt_in,
    rx_unit_if.master         o_spm,
    output logic [CNT_W-1:0]  o_pkt_cnt,
    output logic              o_rx_err,
    input  logic              i_err_clr,
    output logic              o_irq_valid,
    output logic [ADDR_W:0]   o_irq_addr
);
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PAYLOAD = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W:0]   r_wptr;
    logic              r_irq;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_en;
    logic              r_wr;
    logic [63:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              r_irq_valid;
    logic [ADDR_W:0]   r_irq_addr;

    logic              w_valid;
    logic              w_sop;
    logic              w_eop;
    logic [31:0]       w_data;
    logic [ADDR_W:0]   w_hdr_addr;
    logic              w_hdr;
    logic              w_pay;
    logic              w_err_set;

    assign w_valid    = i_pkt_in[34];
    assign w_sop      = i_pkt_in[33];
    assign w_eop      = i_pkt_in[32];
    assign w_data     = i_pkt_in[31:0];
    assign w_hdr_addr = i_pkt_in[ADDR_W:0];
    assign w_hdr      = w_valid & w_sop;
    assign w_pay      = w_valid & ~w_sop & (r_state == S_PAYLOAD);
    assign w_err_set  = w_valid & ((w_sop & (r_state == S_PAYLOAD)) |
                                   (~w_sop & (r_state == S_IDLE)));

    // Packet framing FSM and write pointer / irq tag tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_irq   <= 1'b0;
        end else if (w_hdr) begin
            r_wptr  <= w_hdr_addr;
            r_irq   <= w_data[31];
            r_state <= w_eop ? S_IDLE : S_PAYLOAD;
        end else if (w_pay) begin
            r_wptr  <= r_wptr + 1'b1;
            if (w_eop) begin
                r_state <= S_IDLE;
            end
        end
    end

    // SPM write port: strobe only on payload, address/data hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_en    <= 2'b00;
            r_wr    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_en <= 2'b00;
            r_wr <= 1'b0;
            if (w_pay) begin
                r_addr  <= r_wptr[ADDR_W:1];
                r_en    <= r_wptr[0] ? 2'b01 : 2'b10;
                r_wr    <= 1'b1;
                r_wdata <= {w_data, w_data};
            end
        end
    end

    // Completed-packet counter and IRQ pulse on eop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_irq_valid <= 1'b0;
            r_irq_addr  <= '0;
        end else begin
            r_irq_valid <= 1'b0;
            if (w_hdr && w_eop) begin
                r_cnt       <= r_cnt + 1'b1;
                r_irq_valid <= w_data[31];
                if (w_data[31]) begin
                    r_irq_addr <= w_hdr_addr;
                end
            end else if (w_pay && w_eop) begin
                r_cnt       <= r_cnt + 1'b1;
                r_irq_valid <= r_irq;
                if (r_irq) begin
                    r_irq_addr <= r_wptr;
                end
            end
        end
    end

    // Sticky framing error; a new error wins over a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign o_spm.rx_spm_addr  = r_addr;
    assign o_spm.rx_spm_en    = r_en;
    assign o_spm.rx_spm_wr    = r_wr;
    assign o_spm.rx_spm_wdata = r_wdata;
    assign o_pkt_cnt          = r_cnt;
    assign o_rx_err           = r_err;
    assign o_irq_valid        = r_irq_valid;
    assign o_irq_addr         = r_irq_addr;
endmodule

// File: tb/tb_rx_unit.sv
// tb_rx_unit: randomized + directed bench for rx_unit with a
// packet-level reference model and a per-cycle compare process.
module tb_rx_unit;
    logic        clk;
    logic        reset;
    logic [34:0] pkt;
    logic        err_clr;
    logic [15:0] pkt_cnt;
    logic        rx_err;
    logic        irq_valid;
    logic [14:0] irq_addr;

    rx_unit_if #(.ADDR_W(14)) spm ();

    rx_unit #(.ADDR_W(14), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_pkt_in   (pkt),
        .o_spm      (spm),
        .o_pkt_cnt  (pkt_cnt),
        .o_rx_err   (rx_err),
        .i_err_clr  (err_clr),
        .o_irq_valid(irq_valid),
        .o_irq_addr (irq_addr)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 0;

    // reference model state (packet level)
    bit          m_busy;
    bit          m_irq;
    bit          m_err;
    int          m_ptr;
    int          m_cnt;
    int          m_iaddr;
    logic [13:0] e_addr;
    logic [1:0]  e_en;
    logic        e_wr;
    logic [63:0] e_wdata;
    logic        e_irqv;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [34:0] hdr(input bit irq, input int a,
                                         input bit eop);
        logic [31:0] d;
        d = 32'(a) & 32'h7FFF;
        d[31] = irq;
        return {1'b1, 1'b1, eop, d};
    endfunction

    function automatic logic [34:0] pay(input logic [31:0] d,
                                         input bit eop);
        return {1'b1, 1'b0, eop, d};
    endfunction

    // Expected outputs after the next clock edge for this input
    task automatic model(input logic [34:0] f, input bit clr,
                         input bit rst);
        bit set;
        set = 0;
        e_en = 2'b00;
        e_wr = 1'b0;
        e_irqv = 1'b0;
        if (rst) begin
            m_busy = 0; m_irq = 0; m_err = 0;
            m_ptr = 0; m_cnt = 0; m_iaddr = 0;
            e_addr = '0; e_wdata = '0;
            return;
        end
        if (f[34]) begin
            if (f[33]) begin
                if (m_busy) set = 1;
                m_ptr = int'(f[14:0]);
                m_irq = f[31];
                if (f[32]) begin
                    m_cnt = (m_cnt + 1) % 65536;
                    if (m_irq) begin
                        e_irqv = 1'b1;
                        m_iaddr = m_ptr;
                    end
                    m_busy = 0;
                end else begin
                    m_busy = 1;
                end
            end else if (!m_busy) begin
                set = 1;
            end else begin
                e_addr = 14'(m_ptr / 2);
                e_en = (m_ptr % 2 == 1) ? 2'b01 : 2'b10;
                e_wr = 1'b1;
                e_wdata = {f[31:0], f[31:0]};
                if (f[32]) begin
                    m_cnt = (m_cnt + 1) % 65536;
                    if (m_irq) begin
                        e_irqv = 1'b1;
                        m_iaddr = m_ptr;
                    end
                    m_busy = 0;
                end
                m_ptr = (m_ptr + 1) % 32768;
            end
        end
        if (set) m_err = 1;
        else if (clr) m_err = 0;
    endtask

    task automatic step(input logic [34:0] f, input bit clr = 0,
                        input bit rst = 0);
        @(negedge clk);
        pkt = f;
        err_clr = clr;
        reset = rst;
        model(f, clr, rst);
        chk_on = 1;
        @(posedge clk);
        #2;
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(posedge clk) begin
        if (chk_on) begin
            #1;
            chk("spm_en", 64'(spm.rx_spm_en), 64'(e_en));
            chk("spm_wr", 64'(spm.rx_spm_wr), 64'(e_wr));
            chk("spm_addr", 64'(spm.rx_spm_addr), 64'(e_addr));
            chk("spm_wdata", spm.rx_spm_wdata, e_wdata);
            chk("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
            chk("rx_err", 64'(rx_err), 64'(m_err));
            chk("irq_valid", 64'(irq_valid), 64'(e_irqv));
            if (e_irqv) chk("irq_addr", 64'(irq_addr), 64'(m_iaddr));
        end
    end

    localparam logic [34:0] BUBBLE = 35'h0;

    initial begin
        pkt = '0;
        err_clr = 1'b0;
        reset = 1'b1;

        // T1: header A=0x10, three payload words
        step(BUBBLE, 0, 1);
        chk("t1_reset_en", 64'(spm.rx_spm_en), 64'd0);
        chk("t1_reset_cnt", 64'(pkt_cnt), 64'd0);
        step(hdr(0, 'h10, 0));
        chk("t1_hdr_nowrite", 64'(spm.rx_spm_wr), 64'd0);
        step(pay(32'hA, 0));
        chk("t1_w0_addr", 64'(spm.rx_spm_addr), 64'd8);
        chk("t1_w0_en", 64'(spm.rx_spm_en), 64'b10);
        chk("t1_w0_data", spm.rx_spm_wdata, 64'h0000000A_0000000A);
        step(pay(32'hB, 0));
        chk("t1_w1_addr", 64'(spm.rx_spm_addr), 64'd8);
        chk("t1_w1_en", 64'(spm.rx_spm_en), 64'b01);
        step(pay(32'hC, 1));
        chk("t1_w2_addr", 64'(spm.rx_spm_addr), 64'd9);
        chk("t1_w2_en", 64'(spm.rx_spm_en), 64'b10);
        chk("t1_cnt", 64'(pkt_cnt), 64'd1);

        // T2: irq packet with pointer wraparound
        step(BUBBLE, 0, 1);
        step(hdr(1, 'h7FFF, 0));
        step(pay(32'h1111, 0));
        chk("t2_w0_addr", 64'(spm.rx_spm_addr), 64'h3FFF);
        chk("t2_w0_en", 64'(spm.rx_spm_en), 64'b01);
        chk("t2_w0_irq", 64'(irq_valid), 64'd0);
        step(pay(32'h2222, 1));
        chk("t2_w1_addr", 64'(spm.rx_spm_addr), 64'd0);
        chk("t2_w1_en", 64'(spm.rx_spm_en), 64'b10);
        chk("t2_irq", 64'(irq_valid), 64'd1);
        chk("t2_irq_addr", 64'(irq_addr), 64'd0);
        step(BUBBLE);
        chk("t2_irq_once", 64'(irq_valid), 64'd0);

        // T3: orphan payload then error clear
        step(BUBBLE, 0, 1);
        step(pay(32'h5, 0));
        chk("t3_nowrite", 64'(spm.rx_spm_wr), 64'd0);
        chk("t3_err", 64'(rx_err), 64'd1);
        step(BUBBLE, 1);
        chk("t3_clr", 64'(rx_err), 64'd0);

        // T4: sop interrupts a packet
        step(BUBBLE, 0, 1);
        step(hdr(0, 'h20, 0));
        step(pay(32'h77, 0));
        step(hdr(0, 'h40, 0));
        chk("t4_err", 64'(rx_err), 64'd1);
        chk("t4_cnt", 64'(pkt_cnt), 64'd0);
        step(pay(32'h88, 1));
        chk("t4_addr", 64'(spm.rx_spm_addr), 64'h20);
        chk("t4_en", 64'(spm.rx_spm_en), 64'b10);
        chk("t4_cnt2", 64'(pkt_cnt), 64'd1);

        // T5: bubbles and a header-only packet
        step(BUBBLE, 0, 1);
        step(hdr(0, 'h4, 0));
        step(pay(32'h1, 0));
        step(BUBBLE);
        chk("t5_bubble", 64'(spm.rx_spm_en), 64'd0);
        step(BUBBLE);
        step(pay(32'h2, 1));
        chk("t5_addr", 64'(spm.rx_spm_addr), 64'd2);
        chk("t5_en", 64'(spm.rx_spm_en), 64'b01);
        step(hdr(1, 'h123, 1));
        chk("t5_hdronly_wr", 64'(spm.rx_spm_wr), 64'd0);
        chk("t5_hdronly_cnt", 64'(pkt_cnt), 64'd2);
        chk("t5_hdronly_irq", 64'(irq_addr), 64'h123);

        // T6: reset mid-packet, then counter wrap
        step(hdr(0, 'h30, 0));
        step(pay(32'h9, 0));
        step(pay(32'hA, 0), 0, 1);
        chk("t6_rst_en", 64'(spm.rx_spm_en), 64'd0);
        chk("t6_rst_addr", 64'(spm.rx_spm_addr), 64'd0);
        chk("t6_rst_data", spm.rx_spm_wdata, 64'd0);
        chk("t6_rst_cnt", 64'(pkt_cnt), 64'd0);
        step(pay(32'hB, 1));
        chk("t6_drop", 64'(spm.rx_spm_wr), 64'd0);
        chk("t6_err", 64'(rx_err), 64'd1);
        for (int i = 0; i < 65535; i++) step(hdr(0, i, 1));
        chk("t6_cnt_max", 64'(pkt_cnt), 64'hFFFF);
        step(hdr(0, 'h1, 1));
        chk("t6_cnt_wrap", 64'(pkt_cnt), 64'd0);

        // Randomized traffic
        step(BUBBLE, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            logic [34:0] f;
            logic [31:0] d;
            bit v, s, e, c, r;
            d = $urandom;
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) < 2);
            e = ($urandom_range(0, 9) < 3);
            c = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 199) == 0);
            f = {v, s, e, d};
            step(f, c, r);
        end

        chk_on = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
